fpmul_exp_arbiter: RTL
======================

FPMUL_EXP_ARBITER -- requirements
Module: fpmul_exp_arbiter

Interface
REQ-001 Parameter WEXPSUM, default 10, exponent-sum width in 2's complement.
REQ-002 Parameter BIAS, default 127, exponent bias subtracted from each sum.
REQ-003 Parameter EXPMAX, default 255, smallest non-negative sum flagged huge (used only when FPMUL_EXP_HUGE_EN is defined).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 a_valid  in  1  requester A has an operation.
REQ-007 a_ready  out  1  requester A operation accepted this cycle.
REQ-008 a_expa, a_expb  in  WEXPSUM each  requester A exponents, 2's complement.
REQ-009 a_twoormore  in  1  requester A mantissa product outside [1,2).
REQ-010 b_valid, b_ready, b_expa, b_expb, b_twoormore  as REQ-006..009 for requester B.
REQ-011 out_valid  out  1  result available.
REQ-012 out_ready  in  1  consumer accepts result.
REQ-013 out_expsum  out  WEXPSUM  expa + expb - BIAS + twoormore, modulo 2^WEXPSUM.
REQ-014 out_tiny  out  1  result exponent below 1.
REQ-015 out_id  out  1  source of result: 0 = A, 1 = B.
REQ-016 out_huge  out  1  result overflow flag; present only with FPMUL_EXP_HUGE_EN.

Function
REQ-017 Block SHALL time-share one exponent-sum datapath between A and B through a 2-stage pipeline: S1 (registered operands, id) and S2 (registered result, flags, id).
REQ-018 Transfer on a requester port SHALL occur only in a cycle where valid and ready are both high; the output transfer SHALL occur only when out_valid and out_ready are both high.
REQ-019 S2 SHALL load when S1 valid and (S2 empty or out_ready); S1 SHALL accept when S1 empty or S1 moves to S2 in the same cycle.
REQ-020 a_ready/b_ready SHALL be combinational from valids, S1 accept condition and the round-robin pointer; at most one SHALL be high per cycle; ready SHALL never be high for a port whose valid is low.
REQ-021 Arbitration: single requester valid -> that requester granted; both valid -> requester not served by the last transfer granted; pointer updates only on a transfer.
REQ-022 Latency: operation accepted at edge N SHALL appear on out_* with out_valid high after edge N+2 when not back-pressured; sustained throughput one result per cycle.
REQ-023 Sum SHALL be computed in S1->S2 transition with WEXPSUM-bit wrap-around, no saturation.
REQ-024 out_tiny SHALL be 1 when bits [WEXPSUM-2:0] of the sum are all zero or bit WEXPSUM-1 is 1.
REQ-025 While out_valid high and out_ready low, out_expsum, out_tiny, out_id, out_huge SHALL remain stable.
REQ-026 With both stages full and out_ready low, both ready outputs SHALL be low; out_ready high in that state SHALL allow a new acceptance in the same cycle.
REQ-027 Results SHALL exit in acceptance order; no operation dropped or duplicated.

Reset
REQ-028 rst_n low SHALL asynchronously clear S1/S2 valids, out_valid=0, out_expsum=0, out_tiny=0, out_id=0, out_huge=0, pointer = last served B (A wins first tie).
REQ-029 Reset mid-operation SHALL discard all in-flight operations; no result emerges after release.
REQ-030 a_ready and b_ready SHALL be 0 while rst_n is low.

Configuration
REQ-031 Macro FPMUL_EXP_HUGE_EN defined: out_huge port exists, equals 1 when sum sign bit is 0 and sum >= EXPMAX, registered with S2.
REQ-032 Macro FPMUL_EXP_HUGE_EN undefined: no out_huge port, no related logic; all other behaviour identical.

Verification
REQ-033 A only, expa=127, expb=127, twoormore=0 -> after 2 edges out_expsum=127, out_tiny=0, out_id=0.
REQ-034 A: expa=10, expb=20, twoormore=0 -> out_expsum=10'h39F, out_tiny=1; B: expa=60, expb=67, twoormore=0 -> out_expsum=0, out_tiny=1, out_id=1.
REQ-035 A and B valid continuously for 6 cycles, out_ready=1 -> out_id sequence 0,1,0,1,0,1, one result per cycle.
REQ-036 out_ready=0 for 4 cycles with both requesters valid -> two acceptances then a_ready=b_ready=0, outputs stable; out_ready=1 -> results drain in order.
REQ-037 rst_n low for 1 cycle with S1 and S2 full -> out_valid=0 immediately, no result after release.
REQ-038 FPMUL_EXP_HUGE_EN defined, expa=200, expb=200, twoormore=0 -> out_expsum=273, out_huge=1; expa=150, expb=100 -> out_expsum=123, out_huge=0.

Source files
------------

// File: rtl/fpmul_exp_arbiter.sv
// fpmul_exp_arbiter: two requesters share one round-robin 2-stage exponent-sum pipeline; FPMUL_EXP_HUGE_EN adds out_huge_o
module fpmul_exp_arbiter #(
   parameter int WEXPSUM = 10,
   parameter int BIAS    = 127,
   parameter int EXPMAX  = 255
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               a_valid_i,
   output logic               a_ready_o,
   input  logic [WEXPSUM-1:0] a_expa_i,
   input  logic [WEXPSUM-1:0] a_expb_i,
   input  logic               a_twoormore_i,
   input  logic               b_valid_i,
   output logic               b_ready_o,
   input  logic [WEXPSUM-1:0] b_expa_i,
   input  logic [WEXPSUM-1:0] b_expb_i,
   input  logic               b_twoormore_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [WEXPSUM-1:0] out_expsum_o,
   output logic               out_tiny_o,
`ifdef FPMUL_EXP_HUGE_EN
   output logic               out_huge_o,
`endif
   output logic               out_id_o
);
   logic               s1_valid_q, s1_valid_d, s1_id_q, s1_id_d, s1_two_q, s1_two_d;
   logic [WEXPSUM-1:0] s1_expa_q, s1_expa_d, s1_expb_q, s1_expb_d;
   logic               s2_valid_q, s2_valid_d, s2_id_q, s2_id_d, s2_tiny_q, s2_tiny_d;
   logic [WEXPSUM-1:0] s2_sum_q, s2_sum_d, sum;
   logic               ptr_q, ptr_d;
   logic               s2_load, s1_accept, grant_b, take;
`ifdef FPMUL_EXP_HUGE_EN
   logic               s2_huge_q, s2_huge_d;
`endif

   // handshakes, round-robin grant (ptr_q = id served last) and S1 next state
   always_comb begin
      s2_load    = s1_valid_q & (~s2_valid_q | out_ready_i);
      s1_accept  = rst_ni & (~s1_valid_q | s2_load);
      grant_b    = b_valid_i & (~a_valid_i | ~ptr_q);
      a_ready_o  = s1_accept & a_valid_i & ~grant_b;
      b_ready_o  = s1_accept & grant_b;
      take       = a_ready_o | b_ready_o;
      ptr_d      = take ? b_ready_o : ptr_q;
      s1_valid_d = take | (s1_valid_q & ~s2_load);
      s1_id_d    = take ? b_ready_o : s1_id_q;
      s1_expa_d  = take ? (b_ready_o ? b_expa_i : a_expa_i) : s1_expa_q;
      s1_expb_d  = take ? (b_ready_o ? b_expb_i : a_expb_i) : s1_expb_q;
      s1_two_d   = take ? (b_ready_o ? b_twoormore_i : a_twoormore_i) : s1_two_q;
   end

   // wrap-around exponent sum and flags computed on the S1->S2 move
   always_comb begin
      sum        = s1_expa_q + s1_expb_q - WEXPSUM'(BIAS) + {{(WEXPSUM-1){1'b0}}, s1_two_q};
      s2_valid_d = s2_load | (s2_valid_q & ~out_ready_i);
      s2_sum_d   = s2_load ? sum : s2_sum_q;
      s2_tiny_d  = s2_load ? (~|sum[WEXPSUM-2:0] | sum[WEXPSUM-1]) : s2_tiny_q;
      s2_id_d    = s2_load ? s1_id_q : s2_id_q;
`ifdef FPMUL_EXP_HUGE_EN
      s2_huge_d  = s2_load ? (~sum[WEXPSUM-1] & (sum >= WEXPSUM'(EXPMAX))) : s2_huge_q;
`endif
   end

   // pipeline and pointer registers; reset empties both stages and favours A first
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_valid_q <= 1'b0;
         s1_id_q    <= 1'b0;
         s1_two_q   <= 1'b0;
         s1_expa_q  <= '0;
         s1_expb_q  <= '0;
         s2_valid_q <= 1'b0;
         s2_id_q    <= 1'b0;
         s2_tiny_q  <= 1'b0;
         s2_sum_q   <= '0;
         ptr_q      <= 1'b1;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_id_q    <= s1_id_d;
         s1_two_q   <= s1_two_d;
         s1_expa_q  <= s1_expa_d;
         s1_expb_q  <= s1_expb_d;
         s2_valid_q <= s2_valid_d;
         s2_id_q    <= s2_id_d;
         s2_tiny_q  <= s2_tiny_d;
         s2_sum_q   <= s2_sum_d;
         ptr_q      <= ptr_d;
      end
   end

`ifdef FPMUL_EXP_HUGE_EN
   // overflow flag travels with S2
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) s2_huge_q <= 1'b0;
      else s2_huge_q <= s2_huge_d;
   end
   assign out_huge_o = s2_huge_q;
`endif

   assign out_valid_o  = s2_valid_q;
   assign out_expsum_o = s2_sum_q;
   assign out_tiny_o   = s2_tiny_q;
   assign out_id_o     = s2_id_q;
endmodule
